// File: rtl/awg_wave_reader.sv
// Waveform BRAM read-side playback engine: walks [start..end] N times and streams samples out.
// Optional define AWG_RD_LAST_EN adds an m_last sideband that marks samples read from the end address.
module awg_wave_reader #(
    parameter int P_ADDR_WIDTH = 8,
    parameter int P_DATA_WIDTH = 32,
    parameter int P_LOOP_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    stop,
    input  logic [P_ADDR_WIDTH-1:0] cfg_start_addr,
    input  logic [P_ADDR_WIDTH-1:0] cfg_end_addr,
    input  logic [P_LOOP_WIDTH-1:0] cfg_loop_cnt,
    output logic                    busy,
    output logic                    done,
    output logic [P_ADDR_WIDTH-1:0] bram_addr,
    input  logic [P_DATA_WIDTH-1:0] bram_dout,
    output logic                    m_valid,
    input  logic                    m_ready,
`ifdef AWG_RD_LAST_EN
    output logic                    m_last,
`endif
    output logic [P_DATA_WIDTH-1:0] m_data
);

`ifdef AWG_RD_LAST_EN
    localparam int FW = P_DATA_WIDTH + 1;
`else
    localparam int FW = P_DATA_WIDTH;
`endif

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t                  state_reg, state_next;
    logic [P_ADDR_WIDTH-1:0] start_addr_reg;
    logic [P_ADDR_WIDTH-1:0] end_addr_reg;
    logic [P_ADDR_WIDTH-1:0] bram_addr_reg;
    logic [P_LOOP_WIDTH-1:0] pass_cnt_reg;
    logic                    pend_reg;
`ifdef AWG_RD_LAST_EN
    logic                    pend_last_reg;
`endif
    logic [FW-1:0]           fifo_mem [4];
    logic [1:0]              wr_ptr_reg;
    logic [1:0]              rd_ptr_reg;
    logic [2:0]              fifo_cnt_reg;
    logic                    done_reg;

    logic          rd_issue;
    logic          at_end;
    logic          final_issue;
    logic          push;
    logic          pop;
    logic          drain_empty;
    logic          start_acc;
    logic [FW-1:0] head;
    logic [FW-1:0] push_word;

    assign head = fifo_mem[rd_ptr_reg];
    assign push = pend_reg;
    assign pop  = (fifo_cnt_reg != 3'd0) && m_ready;

    // Buffered plus in-flight samples never exceed the FIFO depth, so a push always has room.
    assign rd_issue    = (state_reg == S_RUN) && !stop &&
                         (({1'b0, fifo_cnt_reg} + {3'b000, pend_reg}) < 4'd4);
    assign at_end      = (bram_addr_reg == end_addr_reg);
    assign final_issue = rd_issue && at_end && (pass_cnt_reg == P_LOOP_WIDTH'(1));
    assign start_acc   = (state_reg == S_IDLE) && start;
    // Counts the pop happening on this edge so done follows the last transfer directly.
    assign drain_empty = !pend_reg &&
                         ((fifo_cnt_reg == 3'd0) || ((fifo_cnt_reg == 3'd1) && pop));

`ifdef AWG_RD_LAST_EN
    assign push_word = {pend_last_reg, bram_dout};
`else
    assign push_word = bram_dout;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= (state_reg == S_DRAIN) && drain_empty;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (stop || final_issue) state_next = S_DRAIN;
            S_DRAIN: if (drain_empty) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_reg != S_IDLE);
        done      = done_reg;
        bram_addr = bram_addr_reg;
        m_valid   = (fifo_cnt_reg != 3'd0);
        m_data    = m_valid ? head[P_DATA_WIDTH-1:0] : '0;
`ifdef AWG_RD_LAST_EN
        m_last    = m_valid ? head[FW-1] : 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_addr_reg <= '0;
            end_addr_reg   <= '0;
            bram_addr_reg  <= '0;
            pass_cnt_reg   <= '0;
            pend_reg       <= 1'b0;
`ifdef AWG_RD_LAST_EN
            pend_last_reg  <= 1'b0;
`endif
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fifo_cnt_reg   <= '0;
        end else begin
            if (start_acc) begin
                start_addr_reg <= cfg_start_addr;
                end_addr_reg   <= cfg_end_addr;
                bram_addr_reg  <= cfg_start_addr;
                pass_cnt_reg   <= cfg_loop_cnt;
            end else if (rd_issue) begin
                if (at_end) begin
                    bram_addr_reg <= start_addr_reg;
                    // A count of zero means loop forever, so it must never wrap to all-ones.
                    if (pass_cnt_reg != '0) pass_cnt_reg <= pass_cnt_reg - 1'b1;
                end else begin
                    bram_addr_reg <= bram_addr_reg + 1'b1;
                end
            end
            pend_reg <= rd_issue;
`ifdef AWG_RD_LAST_EN
            pend_last_reg <= rd_issue && at_end;
`endif
            if (push) wr_ptr_reg <= wr_ptr_reg + 2'd1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 2'd1;
            fifo_cnt_reg <= fifo_cnt_reg + {2'b00, push} - {2'b00, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_reg] <= push_word;
    end

endmodule
